fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: FETCH_CTRL

Interface
REQ-001 Parameter: DATA_WIDTH, 32, instruction word and address width.
REQ-002 Parameter: TIMEOUT_CYCLES, 16, consecutive unacknowledged request cycles before error; legal range 2..255.
REQ-003 Port: fc_clock_in  input  1  single clock; all state updates on rising edge.
REQ-004 Port: fc_reset_in  input  1  synchronous, active-high reset.
REQ-005 Port: fc_pc_addr_in  input  DATA_WIDTH  current PC from IFU.
REQ-006 Port: fc_redirect_in  input  1  jump/branch taken this cycle; IFU select lines held valid while high.
REQ-007 Port: fc_stall_in  input  1  downstream decode cannot accept the held instruction.
REQ-008 Port: fc_mem_ack_in  input  1  instruction memory read data valid.
REQ-009 Port: fc_mem_data_in  input  DATA_WIDTH  instruction memory read data.
REQ-010 Port: fc_mem_req_out  output  1  read request to instruction memory.
REQ-011 Port: fc_mem_addr_out  output  DATA_WIDTH  registered read address.
REQ-012 Port: fc_pc_set_out  output  1  PC load enable to IFU.
REQ-013 Port: fc_ir_set_out  output  1  IR load enable to IFU.
REQ-014 Port: fc_ir_data_out  output  DATA_WIDTH  captured instruction word, to IFU IR data input.
REQ-015 Port: fc_inst_valid_out  output  1  held instruction valid for decode.
REQ-016 Port: fc_error_out  output  1  sticky fetch timeout flag.

Function
REQ-017 States SHALL be IDLE, REQ, HOLD, ERROR, state-registered.
REQ-018 IDLE SHALL last exactly one cycle, then enter REQ.
REQ-019 On every entry to REQ, fc_mem_addr_out SHALL latch fc_pc_addr_in; it is stable for the whole REQ stay.
REQ-020 fc_mem_req_out SHALL be 1 in every REQ cycle, 0 in all other states.
REQ-021 REQ with fc_mem_ack_in=1, no kill pending, fc_redirect_in=0: capture fc_mem_data_in into fc_ir_data_out, fc_pc_set_out=1 that cycle, next state HOLD.
REQ-022 fc_ir_set_out SHALL be 1 for exactly the first HOLD cycle after each accepted capture.
REQ-023 fc_inst_valid_out SHALL be 1 in every HOLD cycle, 0 otherwise.
REQ-024 HOLD with fc_stall_in=1 SHALL remain in HOLD, fc_ir_data_out unchanged; fc_stall_in=0 SHALL go to REQ next cycle.
REQ-025 fc_redirect_in=1 in IDLE, REQ or HOLD SHALL drive fc_pc_set_out=1 combinationally in that cycle.
REQ-026 Redirect in HOLD (stall ignored): next state REQ, no further ir_set for that instruction.
REQ-027 Redirect in REQ without same-cycle ack: set kill flag; stay in REQ, request held to the old address.
REQ-028 Ack in REQ with kill flag set or fc_redirect_in=1: discard data (no capture, no ir_set), clear kill, re-enter REQ next cycle latching the new PC; fc_pc_set_out=1 only if fc_redirect_in=1.
REQ-029 Latency: ack in cycle T -> fc_inst_valid_out and fc_ir_set_out high in T+1; REQ entry -> minimum 2 cycles to valid.
REQ-030 Timeout counter SHALL clear on REQ entry and on ack, and increment each REQ cycle with ack=0; reaching TIMEOUT_CYCLES SHALL move to ERROR next cycle.
REQ-031 ERROR SHALL hold fc_error_out=1 and force req, pc_set, ir_set and inst_valid to 0, ignoring all inputs except reset.
REQ-032 Ack outside REQ SHALL be ignored.

Reset
REQ-033 fc_reset_in=1 SHALL force, next edge, state IDLE, kill flag 0, counter 0, fc_mem_addr_out 0, fc_ir_data_out 0, fc_error_out 0.
REQ-034 While fc_reset_in=1, all 1-bit outputs SHALL be 0, regardless of ack or redirect.
REQ-035 Reset mid-request SHALL abandon the transaction; a late ack after reset release, before REQ entry, is ignored.

Verification
REQ-036 Reset release, PC=0x00000000, ack 2 cycles after req -> mem_addr 0x0, data 0x00500093 on ir_data_out, ir_set 1-cycle pulse, inst_valid high.
REQ-037 HOLD with stall=1 for 5 cycles -> inst_valid held, no req, ir_data_out unchanged; stall=0 -> req next cycle, mem_addr = new PC 0x4.
REQ-038 Redirect in REQ before ack, target 0x100 -> pc_set pulse same cycle, late ack data dropped (no ir_set), next req to 0x100.
REQ-039 Redirect coincident with ack -> data dropped, pc_set=1, next req to target address.
REQ-040 No ack for 16 REQ cycles -> fc_error_out=1 from next cycle, req=0; only reset clears it.
REQ-041 Reset asserted mid-REQ with ack same cycle -> no capture, outputs zero, IDLE then REQ after release.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: IDLE -> REQ -> HOLD, with redirect kill and sticky timeout ERROR.
// Captured word is valid the cycle after ack; stall parks the word in HOLD, and no request is issued.
module fetch_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  fc_clock_in,
  input  logic                  fc_reset_in,
  input  logic [DATA_WIDTH-1:0] fc_pc_addr_in,
  input  logic                  fc_redirect_in,
  input  logic                  fc_stall_in,
  input  logic                  fc_mem_ack_in,
  input  logic [DATA_WIDTH-1:0] fc_mem_data_in,
  output logic                  fc_mem_req_out,
  output logic [DATA_WIDTH-1:0] fc_mem_addr_out,
  output logic                  fc_pc_set_out,
  output logic                  fc_ir_set_out,
  output logic [DATA_WIDTH-1:0] fc_ir_data_out,
  output logic                  fc_inst_valid_out,
  output logic                  fc_error_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic                    kill;
  logic                    kill_nxt;
  logic [7:0]              cnt;
  logic [7:0]              cnt_nxt;
  logic                    first_hold;
  logic                    capture;
  logic                    enter_req;
  logic                    req;
  logic                    pc_set;
  logic                    inst_valid;
  logic                    error;
  logic [DATA_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   ir_data;

  always_ff @(posedge fc_clock_in) begin
    if (fc_reset_in) begin
      state      <= IDLE;
      kill       <= 1'b0;
      cnt        <= 8'd0;
      first_hold <= 1'b0;
      mem_addr   <= '0;
      ir_data    <= '0;
    end else begin
      state      <= state_nxt;
      kill       <= kill_nxt;
      cnt        <= cnt_nxt;
      first_hold <= capture;
      if (enter_req) begin
        mem_addr <= fc_pc_addr_in;
      end
      if (capture) begin
        ir_data <= fc_mem_data_in;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    kill_nxt   = kill;
    cnt_nxt    = cnt;
    capture    = 1'b0;
    enter_req  = 1'b0;
    req        = 1'b0;
    pc_set     = 1'b0;
    inst_valid = 1'b0;
    error      = 1'b0;

    case (state)
      IDLE: begin
        pc_set    = fc_redirect_in;
        state_nxt = REQ;
        enter_req = 1'b1;
      end

      REQ: begin
        req    = 1'b1;
        pc_set = fc_redirect_in;
        if (fc_mem_ack_in) begin
          kill_nxt = 1'b0;
          cnt_nxt  = 8'd0;
          // A redirect (now or earlier in this request) makes the returning word stale.
          if (kill || fc_redirect_in) begin
            enter_req = 1'b1;
          end else begin
            capture   = 1'b1;
            pc_set    = 1'b1;
            state_nxt = HOLD;
          end
        end else begin
          if (fc_redirect_in) begin
            kill_nxt = 1'b1;
          end
          cnt_nxt = cnt + 8'd1;
          if (cnt == CNT_LAST) begin
            state_nxt = ERROR;
          end
        end
      end

      HOLD: begin
        inst_valid = 1'b1;
        pc_set     = fc_redirect_in;
        if (fc_redirect_in || !fc_stall_in) begin
          state_nxt = REQ;
          enter_req = 1'b1;
        end
      end

      ERROR: begin
        error = 1'b1;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (enter_req) begin
      cnt_nxt = 8'd0;
    end
  end

  // Control strobes are masked by reset so the state left over from before reset cannot leak.
  assign fc_mem_req_out    = req & ~fc_reset_in;
  assign fc_pc_set_out     = pc_set & ~fc_reset_in;
  assign fc_ir_set_out     = first_hold & (state == HOLD) & ~fc_reset_in;
  assign fc_inst_valid_out = inst_valid & ~fc_reset_in;
  assign fc_error_out      = error & ~fc_reset_in;
  assign fc_mem_addr_out   = mem_addr;
  assign fc_ir_data_out    = ir_data;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus a timeout/error sequence.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic        rdr;
  logic        stl;
  logic        ack;
  logic [31:0] dat;
  logic        req;
  logic [31:0] addr;
  logic        pcs;
  logic        irs;
  logic [31:0] ir;
  logic        vld;
  logic        err;

  int total;
  int passed;

  fetch_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .fc_clock_in      (clk),
    .fc_reset_in      (rst),
    .fc_pc_addr_in    (pc),
    .fc_redirect_in   (rdr),
    .fc_stall_in      (stl),
    .fc_mem_ack_in    (ack),
    .fc_mem_data_in   (dat),
    .fc_mem_req_out   (req),
    .fc_mem_addr_out  (addr),
    .fc_pc_set_out    (pcs),
    .fc_ir_set_out    (irs),
    .fc_ir_data_out   (ir),
    .fc_inst_valid_out(vld),
    .fc_error_out     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flags = {req, pc_set, ir_set, inst_valid, error}
  typedef struct {
    logic        rst;
    logic        rdr;
    logic        stl;
    logic        ack;
    logic [31:0] pc;
    logic [31:0] dat;
    logic [4:0]  flags;
    logic [31:0] addr;
    logic [31:0] ir;
  } vec_t;

  localparam int NVEC = 25;
  vec_t tbl [NVEC];

  task automatic drive(input logic r, input logic d, input logic s, input logic a,
                       input logic [31:0] p, input logic [31:0] w);
    @(negedge clk);
    rst = r; rdr = d; stl = s; ack = a; pc = p; dat = w;
    #1;
  endtask

  task automatic check(input string name, input logic [4:0] ef, input logic [31:0] ea,
                       input logic [31:0] ei);
    logic [95:0] got;
    logic [95:0] exp;
    got = {27'd0, req, pcs, irs, vld, err, addr, ir};
    exp = {27'd0, ef, ea, ei};
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got flags=%b addr=%h ir=%h, expected flags=%b addr=%h ir=%h",
               name, got[68:64], got[63:32], got[31:0], ef, ea, ei);
    end
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst = 1'b1; rdr = 1'b0; stl = 1'b0; ack = 1'b0; pc = 32'h0; dat = 32'h0;

    //            rst   rdr   stl   ack   pc            dat            flags     addr          ir
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 32'hAAAA_AAAA, 5'b00000, 32'h0000_0000, 32'h0000_0000};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'hDEAD_BEEF, 5'b00000, 32'h0000_0000, 32'h0000_0000};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'b10000, 32'h0000_0000, 32'h0000_0000};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 5'b10000, 32'h0000_0000, 32'h0000_0000};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h0050_0093, 5'b11000, 32'h0000_0000, 32'h0000_0000};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 5'b00110, 32'h0000_0000, 32'h0050_0093};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 5'b00010, 32'h0000_0000, 32'h0050_0093};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 5'b00010, 32'h0000_0000, 32'h0050_0093};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 5'b00010, 32'h0000_0000, 32'h0050_0093};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0004, 32'h0000_0000, 5'b00010, 32'h0000_0000, 32'h0050_0093};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 32'h0000_0000, 5'b00010, 32'h0000_0000, 32'h0050_0093};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'b11000, 32'h0000_0004, 32'h0050_0093};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'b10000, 32'h0000_0004, 32'h0050_0093};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 32'hBAD0_BAD0, 5'b10000, 32'h0000_0004, 32'h0050_0093};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0100, 32'h0000_0000, 5'b10000, 32'h0000_0100, 32'h0050_0093};
    tbl[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111, 5'b11000, 32'h0000_0100, 32'h0050_0093};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'h2222_2222, 5'b11000, 32'h0000_0200, 32'h0050_0093};
    tbl[17] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0300, 32'h0000_0000, 5'b01110, 32'h0000_0200, 32'h2222_2222};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0300, 32'h0000_0000, 5'b10000, 32'h0000_0300, 32'h2222_2222};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'h3333_3333, 5'b11000, 32'h0000_0300, 32'h2222_2222};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0304, 32'h4444_4444, 5'b00110, 32'h0000_0300, 32'h3333_3333};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0304, 32'h0000_0000, 5'b10000, 32'h0000_0304, 32'h3333_3333};
    tbl[22] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0304, 32'h5555_5555, 5'b00000, 32'h0000_0304, 32'h3333_3333};
    tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0040, 32'h6666_6666, 5'b00000, 32'h0000_0000, 32'h0000_0000};
    tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0000_0000, 5'b10000, 32'h0000_0040, 32'h0000_0000};

    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].rst, tbl[i].rdr, tbl[i].stl, tbl[i].ack, tbl[i].pc, tbl[i].dat);
      check($sformatf("vec%0d", i), tbl[i].flags, tbl[i].addr, tbl[i].ir);
    end

    // vec24 was unacked REQ cycle 1; cycles 2..16 still request with no error.
    for (int k = 2; k <= 16; k++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0040, 32'h0);
      check($sformatf("timeout_req%0d", k), 5'b10000, 32'h0000_0040, 32'h0);
    end

    // ERROR ignores ack, redirect and stall.
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0800, 32'h7777_7777);
      check($sformatf("error_hold%0d", k), 5'b00001, 32'h0000_0040, 32'h0);
    end

    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0800, 32'h0);
    check("error_in_reset", 5'b00000, 32'h0000_0040, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0800, 32'h0);
    check("error_cleared_idle", 5'b00000, 32'h0, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0800, 32'h8888_8888);
    check("req_after_error", 5'b11000, 32'h0000_0800, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0804, 32'h0);
    check("capture_after_error", 5'b00110, 32'h0000_0800, 32'h8888_8888);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
